// File: rtl/voting_pkg.sv
// Shared types and helpers for the vote tally block.
package voting_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StLocked,
    StArmed,
    StAck,
    StResult
  } state_e;

  // Mode input encoding
  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  // Classification of a button vector
  typedef enum logic [1:0] {
    OhZero,
    OhOne,
    OhMulti
  } onehot_e;

  // Widest button vector onehot_check accepts; narrower vectors are zero-extended.
  localparam int unsigned MaxCand = 32;

  // Returns whether vec has no bits, exactly one bit or several bits set.
  function automatic onehot_e onehot_check(input logic [MaxCand-1:0] vec);
    if (vec == '0) begin
      return OhZero;
    end
    // Clearing the lowest set bit leaves zero only for a single set bit.
    if ((vec & (vec - 1'b1)) == '0) begin
      return OhOne;
    end
    return OhMulti;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value and flags attempts to pass it.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  localparam logic [W-1:0] MaxVal = '1;

  logic [W-1:0] cnt_q;

  assign q       = cnt_q;
  assign sat_hit = inc && (cnt_q == MaxVal);

  // Count register: increments on inc until saturated, synchronous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MaxVal)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// One-vote-per-voter tally: officer arms, one debounced vote is accepted,
// the LED confirms it for LED_HOLD cycles, results are readable in result mode.
module vote_tally
  import voting_pkg::*;
#(
  parameter int unsigned N_CAND   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LED_HOLD = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      enable_voter,
  input  logic [N_CAND-1:0]         valid_vote,
  input  logic [$clog2(N_CAND)-1:0] sel,
  output logic                      ready,
  output logic                      vote_ack,
  output logic                      reject,
  output logic [N_CAND-1:0]         led,
  output logic [CNT_W-1:0]          count,
  output logic [CNT_W-1:0]          total,
  output logic                      overflow
);

  localparam int unsigned SelW  = $clog2(N_CAND);
  localparam int unsigned HoldW = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LED_HOLD - 1);

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;

  logic [MaxCand-1:0] vote_ext;
  onehot_e            vote_kind;
  logic               armed_vote;
  logic               accept;
  logic               multi;

  logic [N_CAND-1:0] cand_inc;
  logic [N_CAND-1:0] cand_sat;
  logic [CNT_W-1:0]  cand_q [N_CAND];
  logic [CNT_W-1:0]  total_q;
  logic              total_sat;

  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic              reject_q, reject_d;
  logic [N_CAND-1:0] led_q, led_d;
  logic              overflow_q, overflow_d;

  // Zero-extend the button vector to the helper's fixed width
  always_comb begin
    vote_ext = '0;
    vote_ext[N_CAND-1:0] = valid_vote;
  end

  assign vote_kind  = onehot_check(vote_ext);
  assign armed_vote = (state_q == StArmed) && (mode == MODE_VOTE);
  assign accept     = armed_vote && (vote_kind == OhOne);
  assign multi      = armed_vote && (vote_kind == OhMulti);
  assign cand_inc   = accept ? valid_vote : '0;

  // Per-candidate tallies
  for (genvar i = 0; i < N_CAND; i++) begin : g_cand
    sat_counter #(
      .W (CNT_W)
    ) u_cand_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (cand_inc[i]),
      .clr     (1'b0),
      .q       (cand_q[i]),
      .sat_hit (cand_sat[i])
    );
  end

  // Total of accepted votes, saturating independently of the candidates
  sat_counter #(
    .W (CNT_W)
  ) u_total_cnt (
    .clock   (clock),
    .reset   (reset),
    .inc     (accept),
    .clr     (1'b0),
    .q       (total_q),
    .sat_hit (total_sat)
  );

  // State and LED hold counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StLocked;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StLocked: begin
        if (mode == MODE_RESULT) begin
          state_d = StResult;
        end else if (enable_voter) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        // Switching to result mode drops the armed voter without counting
        if (mode == MODE_RESULT) begin
          state_d = StResult;
        end else if (accept) begin
          state_d = StAck;
          hold_d  = '0;
        end
      end
      StAck: begin
        // Mode is not sampled here so the confirmation is never cut short
        if (hold_q == HoldLast) begin
          state_d = StLocked;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StResult: begin
        if (mode == MODE_VOTE) begin
          state_d = StLocked;
        end
      end
      default: begin
        state_d = StLocked;
        hold_d  = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    ready_d    = (state_d == StArmed);
    ack_d      = accept;
    reject_d   = multi;
    overflow_d = overflow_q | (|cand_sat) | total_sat;
    if (accept) begin
      led_d = valid_vote;
    end else if (state_d == StAck) begin
      led_d = led_q;
    end else begin
      led_d = '0;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      led_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      reject_q   <= reject_d;
      led_q      <= led_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = ready_q;
  assign vote_ack = ack_q;
  assign reject   = reject_q;
  assign led      = led_q;
  assign overflow = overflow_q;

  // Result readout mux; out-of-range sel matches no candidate and reads 0
  always_comb begin
    count = '0;
    total = '0;
    if (state_q == StResult) begin
      total = total_q;
      for (int i = 0; i < N_CAND; i++) begin
        if (SelW'(i) == sel) begin
          count = cand_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_vote_tally.sv
module tb_vote_tally;

  localparam int NC   = 4;
  localparam int WD   = 8;
  localparam int WS   = 2;
  localparam int HOLD = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic          enable_voter = 1'b0;
  logic [NC-1:0] valid_vote = '0;
  logic [1:0]    sel = '0;

  logic          d_ready, d_ack, d_reject, d_overflow;
  logic [NC-1:0] d_led;
  logic [WD-1:0] d_count, d_total;
  logic          s_ready, s_ack, s_reject, s_overflow;
  logic [NC-1:0] s_led;
  logic [WS-1:0] s_count, s_total;

  vote_tally #(.N_CAND(NC), .CNT_W(WD), .LED_HOLD(HOLD)) u_dut (
    .clock(clock), .reset(reset), .mode(mode), .enable_voter(enable_voter),
    .valid_vote(valid_vote), .sel(sel), .ready(d_ready), .vote_ack(d_ack),
    .reject(d_reject), .led(d_led), .count(d_count), .total(d_total),
    .overflow(d_overflow)
  );

  vote_tally #(.N_CAND(NC), .CNT_W(WS), .LED_HOLD(HOLD)) u_sat (
    .clock(clock), .reset(reset), .mode(mode), .enable_voter(enable_voter),
    .valid_vote(valid_vote), .sel(sel), .ready(s_ready), .vote_ack(s_ack),
    .reject(s_reject), .led(s_led), .count(s_count), .total(s_total),
    .overflow(s_overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 locked, 1 armed, 2 showing LED, 3 results
  int            m_phase;
  int            m_hold;
  int            raw [NC];
  int            raw_total;
  bit            m_ovf_d, m_ovf_s;
  bit            m_ack, m_rej;
  logic [NC-1:0] m_led;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int satv(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hold = 0; raw_total = 0;
    for (int i = 0; i < NC; i++) raw[i] = 0;
    m_ovf_d = 0; m_ovf_s = 0; m_ack = 0; m_rej = 0; m_led = '0;
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic model_step();
    int n;
    int idx;
    n = $countones(valid_vote);
    idx = 0;
    m_ack = 0;
    m_rej = 0;
    case (m_phase)
      0: if (mode) m_phase = 3; else if (enable_voter) m_phase = 1;
      1: begin
        if (mode) m_phase = 3;
        else if (n == 1) begin
          for (int c = 0; c < NC; c++) if (valid_vote[c]) idx = c;
          if (raw[idx] >= (1 << WD) - 1 || raw_total >= (1 << WD) - 1) m_ovf_d = 1;
          if (raw[idx] >= (1 << WS) - 1 || raw_total >= (1 << WS) - 1) m_ovf_s = 1;
          raw[idx]++;
          raw_total++;
          m_led = valid_vote;
          m_ack = 1;
          m_hold = 0;
          m_phase = 2;
        end else if (n > 1) m_rej = 1;
      end
      2: begin
        if (m_hold == HOLD - 1) begin
          m_phase = 0;
          m_led = '0;
        end else m_hold++;
      end
      default: if (!mode) m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    int ecd, etd, ecs, ets;
    ecd = (m_phase == 3) ? satv(raw[sel], WD) : 0;
    etd = (m_phase == 3) ? satv(raw_total, WD) : 0;
    ecs = (m_phase == 3) ? satv(raw[sel], WS) : 0;
    ets = (m_phase == 3) ? satv(raw_total, WS) : 0;
    check("ready", d_ready, (m_phase == 1));
    check("vote_ack", d_ack, m_ack);
    check("reject", d_reject, m_rej);
    check("led", d_led, m_led);
    check("count", d_count, ecd);
    check("total", d_total, etd);
    check("overflow", d_overflow, m_ovf_d);
    check("sat_vote_ack", s_ack, m_ack);
    check("sat_count", s_count, ecs);
    check("sat_total", s_total, ets);
    check("sat_overflow", s_overflow, m_ovf_s);
  endtask

  task automatic cycle(input logic md, input logic en, input logic [NC-1:0] vv,
                       input logic [1:0] s);
    @(negedge clock);
    mode = md; enable_voter = en; valid_vote = vv; sel = s;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    mode = 1'b0; enable_voter = 1'b0; valid_vote = '0; sel = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 2'd0);
  endtask

  initial begin
    int lit;
    logic md;

    // Asynchronous reset before any clock edge
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 reset = 1'b1;

    // Arm then vote for candidate 2
    cycle(1'b0, 1'b1, 4'b0000, 2'd0);
    check("tp1_ready_armed", d_ready, 1'b1);
    cycle(1'b0, 1'b0, 4'b0100, 2'd0);
    check("tp1_ack", d_ack, 1'b1);
    check("tp1_ready_after", d_ready, 1'b0);
    lit = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 4'b0000, 2'd0);
      if (d_led == 4'b0100) lit++;
    end
    check("tp1_led_cycles", lit, HOLD);
    cycle(1'b1, 1'b0, 4'b0000, 2'd2);
    check("tp1_count", d_count, 1);
    check("tp1_total", d_total, 1);

    // Multi-hot reject, then a clean vote for candidate 0
    cycle(1'b0, 1'b0, 4'b0000, 2'd0);
    cycle(1'b0, 1'b1, 4'b0000, 2'd0);
    cycle(1'b0, 1'b0, 4'b0011, 2'd0);
    check("tp2_reject", d_reject, 1'b1);
    check("tp2_ready", d_ready, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 2'd0);
    check("tp2_reject_once", d_reject, 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 2'd0);
    idle(HOLD);
    cycle(1'b1, 1'b0, 4'b0000, 2'd0);
    check("tp2_count0", d_count, 1);

    // Unarmed presses are ignored; arm plus press in one cycle only arms
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'b1000, 2'd0);
    cycle(1'b0, 1'b1, 4'b1000, 2'd0);
    check("tp3_arm_only_ack", d_ack, 1'b0);
    cycle(1'b1, 1'b0, 4'b0000, 2'd3);
    check("tp3_count", d_count, 0);
    check("tp3_total", d_total, 0);

    // Saturation on the narrow instance
    do_reset();
    for (int v = 0; v < 4; v++) begin
      cycle(1'b0, 1'b1, 4'b0000, 2'd1);
      cycle(1'b0, 1'b0, 4'b0010, 2'd1);
      check("tp4_sat_ack", s_ack, 1'b1);
      idle(HOLD);
    end
    cycle(1'b1, 1'b0, 4'b0000, 2'd1);
    check("tp4_sat_count", s_count, 3);
    check("tp4_sat_total", s_total, 3);
    check("tp4_sat_ovf", s_overflow, 1'b1);
    check("tp4_wide_count", d_count, 4);
    check("tp4_wide_ovf", d_overflow, 1'b0);

    // Result mode requested during the LED hold
    cycle(1'b0, 1'b0, 4'b0000, 2'd0);
    cycle(1'b0, 1'b1, 4'b0000, 2'd0);
    cycle(1'b0, 1'b0, 4'b1000, 2'd3);
    for (int i = 0; i < HOLD - 1; i++) begin
      cycle(1'b1, 1'b0, 4'b0000, 2'd3);
      check("tp5_led_held", d_led, 4'b1000);
    end
    cycle(1'b1, 1'b0, 4'b0000, 2'd3);
    cycle(1'b1, 1'b0, 4'b0000, 2'd3);
    check("tp5_result_count", d_count, 1);
    cycle(1'b1, 1'b1, 4'b1000, 2'd3);
    cycle(1'b1, 1'b0, 4'b0001, 2'd3);
    check("tp5_frozen", d_count, 1);

    // Reset in the middle of the LED hold
    cycle(1'b0, 1'b0, 4'b0000, 2'd0);
    cycle(1'b0, 1'b1, 4'b0000, 2'd0);
    cycle(1'b0, 1'b0, 4'b0100, 2'd2);
    cycle(1'b0, 1'b0, 4'b0000, 2'd2);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("tp6_led_async", d_led, 4'b0000);
    compare_all();
    #1 reset = 1'b1;
    cycle(1'b1, 1'b0, 4'b0000, 2'd2);
    check("tp6_count_cleared", d_count, 0);
    check("tp6_ovf_cleared", s_overflow, 1'b0);

    // Randomized traffic against the model
    md = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic [NC-1:0] vv;
      int r;
      if ($urandom_range(0, 29) == 0) md = ~md;
      r = $urandom_range(0, 3);
      if (r == 0) vv = '0;
      else if (r == 3) vv = NC'($urandom);
      else vv = NC'(1) << $urandom_range(0, NC - 1);
      cycle(md, ($urandom_range(0, 3) == 0), vv, 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
